dynamic_lighting_scanner: RTL and testbench
===========================================

# dynamic_lighting_scanner

Multiplexed (dynamic-lighting) driver for a 4-digit common-anode 7-segment display. It sits directly downstream of the dynamic-lighting clock divider and consumes its one-cycle `CE_OUT` pulse on its `CE` input to step through the digits. It inserts a blanking gap between digits to prevent ghosting. New display data is committed only at a frame boundary through a LOAD/ACK handshake, so a frame never shows a mix of old and new data.

## Interface
- `BLANK_CE`, default 1: CE ticks of all-off blanking before each digit; 0 disables blanking.
- `HOLD_CE`, default 3: CE ticks each digit is lit; must be ≥1.
- `CLK`  in  1  system clock. One clock domain only.
- `RST`  in  1  reset, synchronous, active-high.
- `CE`  in  1  scan-step enable, one-cycle pulse from the divider. Continuous high is legal.
- `DATA`  in  16  four hex digits; digit 0 (rightmost) = `DATA[3:0]`, digit 3 = `DATA[15:12]`.
- `DP`  in  4  decimal point per digit, 1 = on; `DP[i]` belongs to digit i.
- `LOAD`  in  1  capture `DATA`/`DP` into staging; single-cycle or held.
- `LOAD_ACK`  out  1  one-cycle pulse when staged data is committed to the display.
- `AN`  out  4  digit anodes, active-low, one-hot-low or all-high.
- `SEG`  out  8  segments, active-low, bit order {DP,G,F,E,D,C,B,A}.
- `FRAME`  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Registers: `state` ∈ {BLANK, SHOW}, `idx` (2b), `tick_cnt`, staging {DATA,DP}, display {DATA,DP}, `pending`.
- State changes occur only on cycles with `CE`=1. All other cycles hold state.
- In BLANK: `AN`=4'b1111, `SEG`=8'hFF. When `tick_cnt`==BLANK_CE-1, go to SHOW and clear `tick_cnt`. Otherwise increment `tick_cnt`.
- In SHOW: `AN[idx]`=0 and the other anodes are 1. `SEG` = hex decode of display digit `idx`, with bit 7 = ~`DP[idx]`.
- In SHOW, when `tick_cnt`==HOLD_CE-1: clear `tick_cnt`, set `idx` = (`idx`+1) mod 4, and go to BLANK. If BLANK_CE=0, stay in SHOW instead.
- Frame boundary is the CE cycle on which `idx` wraps from 3 to 0. `FRAME` pulses on the following cycle.
- Hex decode (active-low, DP off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- `LOAD`=1 copies `DATA`/`DP` into staging on that edge and sets `pending`. A repeated `LOAD` overwrites staging, and only the last value is committed.
- At a frame boundary with `pending`=1: staging is copied to display, `pending` is cleared, and `LOAD_ACK` pulses together with `FRAME`.
- If `LOAD` and a frame boundary fall on the same cycle: the commit uses the previous staging value, and the new `LOAD` remains pending for the next boundary.

## Timing
- Reset values: `state`=BLANK, `idx`=0, `tick_cnt`=0, staging=0, display=0, `pending`=0, `AN`=4'hF, `SEG`=8'hFF, `LOAD_ACK`=0, `FRAME`=0.
- `AN` and `SEG` are decoded from registered state only. They change on the clock edge that samples the stepping `CE`, so output latency is 0 cycles after that edge.
- `FRAME` and `LOAD_ACK` are registered. They are high for exactly the one cycle after the wrap edge.
- Digit period = (BLANK_CE+HOLD_CE) CE ticks. Frame period = 4×(BLANK_CE+HOLD_CE) CE ticks.
- `RST` mid-frame: on the next edge all registers return to reset values. `pending` and staging are lost, and no `LOAD_ACK` is issued.
- `RST` has priority over `CE` and `LOAD` on the same cycle.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: if digit i (i=3..1) is 0 and every more-significant digit is also 0, its segments A–G are forced off (`SEG[6:0]`=7'h7F). `AN` still strobes that digit, and `DP[i]` is still honoured. Digit 0 is always shown.
- `LEADING_ZERO_BLANK_EN` not defined: every digit is decoded, so a zero shows as C0.

## Test plan
- Reset, then `CE` every 4th cycle with default parameters: `AN` sequence is F,E,F,D,F,B,F,7,F,E… Each blank lasts 1 tick and each lit digit lasts 3 ticks. `FRAME` pulses once per 16 ticks.
- `LOAD` with `DATA`=16'h12AF and `DP`=4'b0100 mid-frame: the display holds 0 until the wrap. At the wrap, `LOAD_ACK` and `FRAME` pulse together. Digit 0 then shows 8E, digit 1 shows 88, digit 2 shows 24 (DP on), and digit 3 shows F9.
- `LOAD` 16'h1111 then `LOAD` 16'h2222 in the same frame: exactly one `LOAD_ACK` is issued, and all digits show A4.
- `LOAD` 16'h3333 on the exact wrap cycle: no commit at that boundary. The commit and `LOAD_ACK` happen at the next wrap.
- `RST` asserted during SHOW of digit 2 with a `LOAD` pending: on the next cycle `AN`=F and `SEG`=FF. After reset, no `LOAD_ACK` is ever issued for the lost load.
- With `LEADING_ZERO_BLANK_EN`, load `DATA`=16'h0050: digit 3 shows `SEG`=FF, digit 2 shows FF, digit 1 shows 92, and digit 0 shows C0. `AN` still strobes all four digits.

Source files
------------

// File: rtl/dynamic_lighting_scanner.sv
// Multiplexed 4-digit common-anode 7-segment scanner with inter-digit blanking and frame-aligned data commit.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress segments of leading zero digits 3..1).
module dynamic_lighting_scanner #(
  parameter int BLANK_CE = 1,
  parameter int HOLD_CE  = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic        LOAD,
  output logic        LOAD_ACK,
  output logic [3:0]  AN,
  output logic [7:0]  SEG,
  output logic        FRAME
);

  localparam int CNT_MAX = (BLANK_CE > HOLD_CE) ? BLANK_CE : HOLD_CE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CE > 0) ? BLANK_CE - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [19:0]      stg_q, stg_d;    // {DP, DATA}
  logic [19:0]      disp_q, disp_d;  // {DP, DATA}
  logic             pending_q, pending_d;
  logic             frame_q, frame_d;
  logic             ack_q, ack_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             wrap_s;
  logic [3:0]       digit_s;
  logic             dp_s;

  // Active-low A..G pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
      4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
      4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
      4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit i and every more-significant digit are zero; digit 0 never qualifies
  function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] i);
    logic r;
    case (i)
      2'd3:    r = (d[15:12] == 4'h0);
      2'd2:    r = (d[15:8]  == 8'h00);
      2'd1:    r = (d[15:4]  == 12'h000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  // Scan sequencer: BLANK/SHOW dwell counting, advancing only on CE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    wrap_s  = 1'b0;
    if (CE) begin
      case (state_q)
        ST_BLANK: begin
          if (tick_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            tick_d  = CNT_ZERO;
          end else begin
            tick_d = tick_q + CNT_ONE;
          end
        end
        ST_SHOW: begin
          if (tick_q == HOLD_LAST) begin
            tick_d  = CNT_ZERO;
            idx_d   = idx_q + 2'd1;
            wrap_s  = (idx_q == 2'd3);
            state_d = (BLANK_CE == 0) ? ST_SHOW : ST_BLANK;
          end else begin
            tick_d = tick_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_BLANK;
          tick_d  = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Staging/commit handshake; a LOAD coinciding with the wrap stays pending for the next frame
  always_comb begin
    stg_d     = LOAD ? {DP, DATA} : stg_q;
    disp_d    = (wrap_s && pending_q) ? stg_q : disp_q;
    pending_d = LOAD ? 1'b1 : (wrap_s ? 1'b0 : pending_q);
    frame_d   = wrap_s;
    ack_d     = wrap_s & pending_q;
  end

  // Anode/segment decode of the next state so the registered outputs move on the stepping edge
  always_comb begin
    an_d    = 4'hF;
    seg_d   = 8'hFF;
    digit_s = disp_d[{idx_d, 2'b00} +: 4];
    dp_s    = disp_d[5'd16 + {3'b000, idx_d}];
    if (state_d == ST_SHOW) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = {~dp_s, hex7(digit_s)};
`ifdef LEADING_ZERO_BLANK_EN
      if (lead_zero(disp_d[15:0], idx_d)) begin
        seg_d[6:0] = 7'h7F;
      end else begin
        seg_d[6:0] = hex7(digit_s);
      end
`endif
    end else begin
      an_d  = 4'hF;
      seg_d = 8'hFF;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_BLANK;
      idx_q     <= 2'd0;
      tick_q    <= CNT_ZERO;
      stg_q     <= 20'h00000;
      disp_q    <= 20'h00000;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      ack_q     <= 1'b0;
      an_q      <= 4'hF;
      seg_q     <= 8'hFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      stg_q     <= stg_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      ack_q     <= ack_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign AN       = an_q;
  assign SEG      = seg_q;
  assign FRAME    = frame_q;
  assign LOAD_ACK = ack_q;

endmodule

// File: tb/tb_dynamic_lighting_scanner.sv
// Directed self-checking bench for dynamic_lighting_scanner (default parameters, CE every 4th cycle).
module tb_dynamic_lighting_scanner;

  logic        CLK = 1'b0;
  logic        RST, CE, LOAD;
  logic [15:0] DATA;
  logic [3:0]  DP;
  logic        LOAD_ACK, FRAME;
  logic [3:0]  AN;
  logic [7:0]  SEG;

  int checks = 0;
  int failures = 0;
  int k = 0;
  int frame_cnt = 0;
  int ack_cnt = 0;
  logic last_frame, last_ack;

  dynamic_lighting_scanner dut (
    .CLK(CLK), .RST(RST), .CE(CE), .DATA(DATA), .DP(DP), .LOAD(LOAD),
    .LOAD_ACK(LOAD_ACK), .AN(AN), .SEG(SEG), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    if (FRAME === 1'b1) frame_cnt++;
    if (LOAD_ACK === 1'b1) ack_cnt++;
  endtask

  // One CE tick: CE high for one cycle, then three idle cycles
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
    CE = 1'b1; LOAD = ld; DATA = d; DP = p;
    cyc();
    last_frame = FRAME;
    last_ack   = LOAD_ACK;
    CE = 1'b0; LOAD = 1'b0;
    repeat (3) cyc();
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) step(1'b0, 16'h0000, 4'h0);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    DATA = d; DP = p; LOAD = 1'b1;
    cyc();
    LOAD = 1'b0;
  endtask

  function automatic logic [3:0] exp_an(input int kk);
    logic [3:0] one;
    one = 4'b0001;
    if (kk % 4 == 0) return 4'hF;
    return ~(one << ((kk / 4) % 4));
  endfunction

  // Pattern of a zero digit in a zero-valued upper field
  function automatic logic [7:0] zero_seg(input int digit);
`ifdef LEADING_ZERO_BLANK_EN
    return (digit == 0) ? 8'hC0 : 8'hFF;
`else
    return 8'hC0;
`endif
  endfunction

  initial begin
    RST = 1'b1; CE = 1'b1; LOAD = 1'b1; DATA = 16'hFFFF; DP = 4'hF;
    cyc();
    cyc();
    check("rst_an", {12'h000, AN}, 16'h000F);
    check("rst_seg", {8'h00, SEG}, 16'h00FF);
    check("rst_frame", {15'h0000, FRAME}, 16'h0000);
    check("rst_ack", {15'h0000, LOAD_ACK}, 16'h0000);
    RST = 1'b0; CE = 1'b0; LOAD = 1'b0; DATA = 16'h0000; DP = 4'h0;

    // First frame: anode walk and blank/lit pattern of an all-zero display
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 16'h0000, 4'h0);
      check("walk_an", {12'h000, AN}, {12'h000, exp_an(k)});
      check("walk_seg", {8'h00, SEG},
            {8'h00, (exp_an(k) == 4'hF) ? 8'hFF : zero_seg((k / 4) % 4)});
    end
    check("f1_frame", {15'h0000, last_frame}, 16'h0001);
    check("f1_frame_cnt", 16'(frame_cnt), 16'd1);
    check("f1_no_ack", 16'(ack_cnt), 16'd0);

    // Mid-frame load is held until the wrap
    run_to(18);
    do_load(16'h12AF, 4'b0100);
    check("hold_seg", {8'h00, SEG}, 16'h00C0);
    run_to(31);
    check("hold_ack", 16'(ack_cnt), 16'd0);
    check("hold_seg3", {8'h00, SEG}, {8'h00, zero_seg(3)});
    run_to(32);
    check("f2_frame", {15'h0000, last_frame}, 16'h0001);
    check("f2_ack", {15'h0000, last_ack}, 16'h0001);
    run_to(33); check("d0_an", {12'h000, AN}, 16'h000E); check("d0_seg", {8'h00, SEG}, 16'h008E);
    run_to(37); check("d1_an", {12'h000, AN}, 16'h000D); check("d1_seg", {8'h00, SEG}, 16'h0088);
    run_to(41); check("d2_an", {12'h000, AN}, 16'h000B); check("d2_seg", {8'h00, SEG}, 16'h0024);
    run_to(45); check("d3_an", {12'h000, AN}, 16'h0007); check("d3_seg", {8'h00, SEG}, 16'h00F9);
    check("f2_ack_cnt", 16'(ack_cnt), 16'd1);

    // Two loads in one frame: only the last commits, one ack
    do_load(16'h1111, 4'h0);
    do_load(16'h2222, 4'h0);
    run_to(48);
    check("f3_ack", {15'h0000, last_ack}, 16'h0001);
    for (int t = 49; t <= 61; t += 4) begin
      run_to(t);
      check("f3_seg", {8'h00, SEG}, 16'h00A4);
    end
    run_to(64);
    check("f4_no_ack", {15'h0000, last_ack}, 16'h0000);
    check("f4_ack_cnt", 16'(ack_cnt), 16'd2);

    // Load on the exact wrap cycle defers to the following wrap
    run_to(79);
    step(1'b1, 16'h3333, 4'h0);
    check("wrapld_frame", {15'h0000, last_frame}, 16'h0001);
    check("wrapld_no_ack", {15'h0000, last_ack}, 16'h0000);
    run_to(81);
    check("wrapld_old_seg", {8'h00, SEG}, 16'h00A4);
    run_to(96);
    check("wrapld_ack", {15'h0000, last_ack}, 16'h0001);
    run_to(97);
    check("wrapld_new_seg", {8'h00, SEG}, 16'h00B0);
    check("wrapld_ack_cnt", 16'(ack_cnt), 16'd3);
    check("wrapld_frame_cnt", 16'(frame_cnt), 16'd6);

    // Reset during SHOW of digit 2 with a load pending
    do_load(16'h4444, 4'hF);
    run_to(105);
    check("prerst_an", {12'h000, AN}, 16'h000B);
    RST = 1'b1;
    cyc();
    check("midrst_an", {12'h000, AN}, 16'h000F);
    check("midrst_seg", {8'h00, SEG}, 16'h00FF);
    RST = 1'b0;
    k = 0;
    run_to(1);
    check("postrst_seg", {8'h00, SEG}, 16'h00C0);
    run_to(32);
    check("postrst_ack_cnt", 16'(ack_cnt), 16'd3);
    check("postrst_frame_cnt", 16'(frame_cnt), 16'd8);

    // Zero-heavy data exercises leading-zero handling
    do_load(16'h0050, 4'h0);
    run_to(48);
    check("lz_ack", {15'h0000, last_ack}, 16'h0001);
    run_to(49); check("lz_d0_an", {12'h000, AN}, 16'h000E); check("lz_d0", {8'h00, SEG}, 16'h00C0);
    run_to(53); check("lz_d1_an", {12'h000, AN}, 16'h000D); check("lz_d1", {8'h00, SEG}, 16'h0092);
    run_to(57); check("lz_d2_an", {12'h000, AN}, 16'h000B); check("lz_d2", {8'h00, SEG}, {8'h00, zero_seg(2)});
    run_to(61); check("lz_d3_an", {12'h000, AN}, 16'h0007); check("lz_d3", {8'h00, SEG}, {8'h00, zero_seg(3)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
